// File: rtl/obi_pkg.sv
// ----------------------------------------------------------------------------
// obi_pkg
// OBI initiator-side transaction types.
//   obi_req_t  : req, we, be, addr, wdata  (address phase, driven by master)
//   obi_resp_t : gnt, rvalid, rdata        (grant and response phase)
// ----------------------------------------------------------------------------
package obi_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/reg_pkg.sv
// ----------------------------------------------------------------------------
// reg_pkg
// Register-interface transaction types shared by register-bus agents.
//   reg_req_t : addr, write, wdata, wstrb, valid  (driven by the requester)
//   reg_rsp_t : rdata, error, ready               (driven by the device)
// ----------------------------------------------------------------------------
package reg_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

endpackage

// File: rtl/reg_to_obi_bridge_pkg.sv
// ----------------------------------------------------------------------------
// reg_to_obi_bridge_pkg
// Shared definitions for the register-bus to OBI bridge:
//   state_e           : bridge FSM states
//   ERR_RDATA_DEFAULT : rdata returned when the response watchdog fires
//   reg_obi_txn_t     : request captured from the register bus in IDLE
// ----------------------------------------------------------------------------
package reg_to_obi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT_R = 3'd2,
      RESP   = 3'd3,
      DRAIN  = 3'd4
   } state_e;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } reg_obi_txn_t;

endpackage

// File: rtl/reg_to_obi_timeout_cnt.sv
// ----------------------------------------------------------------------------
// reg_to_obi_timeout_cnt
// Response watchdog counter for reg_to_obi_bridge.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clear   : forces the count to 0 (has priority over enable)
//   enable  : counts up by one per cycle, saturating at Limit-1
//   expired : high while the count equals Limit-1
// Limit must be at least 2.
// ----------------------------------------------------------------------------
module reg_to_obi_timeout_cnt #(
   parameter int unsigned Limit = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(Limit);
   localparam logic [CW-1:0] LAST = CW'(Limit - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/reg_to_obi_bridge.sv
// ----------------------------------------------------------------------------
// reg_to_obi_bridge
// Replays one register-bus transaction at a time as a single OBI master
// transaction (req/gnt address phase, rvalid response phase).
//
// Ports:
//   clk_i         : clock
//   rst_ni        : asynchronous active-low reset
//   reg_req_i     : register-bus request  (addr, write, wdata, wstrb, valid)
//   reg_rsp_o     : register-bus response (rdata, error, ready)
//   master_req_o  : OBI address phase     (req, we, be, addr, wdata)
//   master_resp_i : OBI response          (gnt, rvalid, rdata)
//   busy_o        : high whenever the FSM is not IDLE
//
// Parameters:
//   TimeoutCycles : watchdog limit in cycles from req assertion (>= 2)
//   ErrRdata      : rdata returned on a watchdog timeout
//
// Build option:
//   REG_TO_OBI_BRIDGE_TIMEOUT_EN - enables the response watchdog. On expiry
//   the register bus is answered with error=1/rdata=ErrRdata and the FSM
//   then drains the owed OBI gnt/rvalid in DRAIN before returning to IDLE.
//   Without it the bridge waits indefinitely and error is tied to 0.
//
// All outputs come from registers or from the state register alone; there
// is no combinational path from reg_req_i or master_resp_i to an output.
// ----------------------------------------------------------------------------
module reg_to_obi_bridge
   import reg_to_obi_bridge_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1024,
   parameter logic [31:0] ErrRdata      = ERR_RDATA_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  reg_pkg::reg_req_t   reg_req_i,
   output reg_pkg::reg_rsp_t   reg_rsp_o,
   output obi_pkg::obi_req_t   master_req_o,
   input  obi_pkg::obi_resp_t  master_resp_i,
   output logic                busy_o
);

   state_e       state_q;
   reg_obi_txn_t txn_q;
   logic         req_q;
   logic [31:0]  rdata_q;

`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
   // err_q   : error flag returned with the next ready pulse
   // owed_q  : a timed-out OBI transaction still owes us gnt and/or rvalid
   logic err_q;
   logic owed_q;
   logic cnt_enable;
   logic expired;
   logic drain_done;

   assign cnt_enable = (state_q == REQ) || (state_q == WAIT_R);

   // The abandoned transaction is finished once it has been granted and
   // its rvalid arrives; rvalid can never share a cycle with its own gnt.
   assign drain_done = !req_q && master_resp_i.rvalid;

   reg_to_obi_timeout_cnt #(
      .Limit (TimeoutCycles)
   ) u_timeout_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear   (!cnt_enable),
      .enable  (cnt_enable),
      .expired (expired)
   );
`else
   logic unused_cfg;
   assign unused_cfg = ^{TimeoutCycles, ErrRdata};
`endif

   // NOTE: every state register below is assigned with <= so that all
   // branches see the pre-edge values; blocking = here would create
   // ordering-dependent behaviour and simulation/synthesis mismatches.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         txn_q   <= '0;
         req_q   <= 1'b0;
         rdata_q <= '0;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
         err_q   <= 1'b0;
         owed_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (reg_req_i.valid) begin
                  txn_q <= '{addr:  reg_req_i.addr,
                             we:    reg_req_i.write,
                             be:    reg_req_i.wstrb,
                             wdata: reg_req_i.wdata};
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end
            end

            REQ: begin
               if (master_resp_i.gnt) begin
                  req_q   <= 1'b0;
                  state_q <= WAIT_R;
               end
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
               // Later assignment overrides the WAIT_R move above. req_q
               // is left alone unless granted: OBI req is never retracted.
               if (expired) begin
                  state_q <= RESP;
                  rdata_q <= ErrRdata;
                  err_q   <= 1'b1;
                  owed_q  <= 1'b1;
               end
`endif
            end

            WAIT_R: begin
               if (master_resp_i.rvalid) begin
                  rdata_q <= txn_q.we ? '0 : master_resp_i.rdata;
                  state_q <= RESP;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
                  err_q   <= 1'b0;
`endif
               end
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
               else if (expired) begin
                  state_q <= RESP;
                  rdata_q <= ErrRdata;
                  err_q   <= 1'b1;
                  owed_q  <= 1'b1;
               end
`endif
            end

            RESP: begin
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
               // After a timeout the owed gnt/rvalid may already arrive
               // while the error response is being presented.
               if (owed_q) begin
                  if (req_q) begin
                     if (master_resp_i.gnt) req_q <= 1'b0;
                  end else if (master_resp_i.rvalid) begin
                     owed_q <= 1'b0;
                  end
               end
               state_q <= (owed_q && !drain_done) ? DRAIN : IDLE;
`else
               state_q <= IDLE;
`endif
            end

`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
            DRAIN: begin
               if (req_q) begin
                  if (master_resp_i.gnt) req_q <= 1'b0;
               end else if (master_resp_i.rvalid) begin
                  owed_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
`endif

            default: state_q <= IDLE;
         endcase
      end
   end

   assign master_req_o.req   = req_q;
   assign master_req_o.we    = txn_q.we;
   assign master_req_o.be    = txn_q.be;
   assign master_req_o.addr  = txn_q.addr;
   assign master_req_o.wdata = txn_q.wdata;

   assign reg_rsp_o.ready = (state_q == RESP);
   assign reg_rsp_o.rdata = rdata_q;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
   assign reg_rsp_o.error = err_q;
`else
   assign reg_rsp_o.error = 1'b0;
`endif

   assign busy_o = (state_q != IDLE);

endmodule
